// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the 4-requester round-robin packet arbiter.
package rr_mux_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin pick: first requester after ptr, wrapping back to ptr itself.
module rr_pick_4
  import rr_mux_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant_idx,
  output logic             any_req
);

  always_comb begin
    grant_idx = '0;
    any_req   = 1'b0;
    // Offsets 1..4 visit ptr+1, ptr+2, ptr+3, then ptr (offset 4 wraps to 0).
    for (int k = 1; k <= N_REQ; k++) begin
      if (!any_req && req[ptr + SEL_W'(k)]) begin
        grant_idx = ptr + SEL_W'(k);
        any_req   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin 4:1 packet arbiter: a winner owns the mux until its last beat,
// feeding a single registered valid/ready output stage.
module rr_mux_arbiter_4
  import rr_mux_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  input  logic [3:0]       in_last,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [1:0]       out_src,
  input  logic             out_ready
);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] owner_q, owner_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;

  logic [SEL_W-1:0] grant_idx;
  logic             any_req;
  logic [SEL_W-1:0] sel_idx;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;
  logic [3:0]       in_ready_c;
  logic             load;
  logic             xfer;

  rr_pick_4 u_pick (
    .req       (in_valid),
    .ptr       (ptr_q),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  assign load    = ~out_valid_q | out_ready;
  assign sel_idx = (state_q == LOCK) ? owner_q : grant_idx;

  always_comb begin
    case (sel_idx)
      2'd0:    sel_data = in_data0;
      2'd1:    sel_data = in_data1;
      2'd2:    sel_data = in_data2;
      default: sel_data = in_data3;
    endcase
  end

  assign sel_last = in_last[sel_idx];

  // Only the selected requester ever sees ready; in LOCK it is independent of in_valid.
  always_comb begin
    in_ready_c = '0;
    if (rst_n && (state_q == LOCK || any_req)) in_ready_c[sel_idx] = load;
  end

  assign in_ready = in_ready_c;
  assign xfer     = |(in_valid & in_ready_c);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;

    if (load) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = sel_data;
        out_last_d = sel_last;
        out_src_d  = sel_idx;
      end
    end

    case (state_q)
      ARB: begin
        if (xfer) begin
          ptr_d = grant_idx;
          if (!sel_last) begin
            state_d = LOCK;
            owner_d = grant_idx;
          end
        end
      end
      LOCK: begin
        if (xfer && sel_last) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  // Output register stage and arbitration state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      ptr_q       <= SEL_W'(N_REQ - 1);
      owner_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;

endmodule
